// File: rtl/seg_decoder_personaje.sv
// Debounced 7-segment character decoder: hero/move code 2 edges after the STABLE_N-th equal strobe, no backpressure.
// Optional saturating error counter enabled by macro SEGDEC_ERRCNT_EN (err_count is tied to 0 otherwise).
module seg_decoder_personaje #(
  parameter int unsigned STABLE_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       sample_en,
  output logic [2:0] heroe_out,
  output logic [1:0] mov_out,
  output logic       valid,
  output logic       err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    DECODE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] LP_STABLE = 4'(STABLE_N);
  localparam bit         LP_ONE    = (STABLE_N == 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] r_cand;
  logic [6:0] w_cand_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] w_cnt_inc;
  logic       w_restart;

  logic [2:0] r_heroe;
  logic [1:0] r_mov;
  logic       r_valid;
  logic       r_err;

  logic       w_legal;
  logic       w_is_mov;
  logic [2:0] w_dec_heroe;
  logic [1:0] w_dec_mov;

  assign w_cnt_inc = r_cnt + 4'd1;

  // Character table: hero glyphs set heroe_out, movement glyphs leave it alone.
  always_comb begin
    w_legal     = 1'b1;
    w_is_mov    = 1'b0;
    w_dec_heroe = 3'd0;
    w_dec_mov   = 2'd0;
    case (r_cand)
      7'b0111110: w_dec_heroe = 3'd1;
      7'b0000110: w_dec_heroe = 3'd2;
      7'b1100111: w_dec_heroe = 3'd3;
      7'b1000111: w_dec_heroe = 3'd4;
      7'b1001111: w_dec_heroe = 3'd5;
      7'b0000000: w_dec_heroe = 3'd0;
      7'b1000000: begin w_is_mov = 1'b1; w_dec_mov = 2'd1; end
      7'b0000001: begin w_is_mov = 1'b1; w_dec_mov = 2'd2; end
      7'b0001000: begin w_is_mov = 1'b1; w_dec_mov = 2'd3; end
      default:    w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_restart   = 1'b0;
    case (r_state)
      IDLE: begin
        if (sample_en) w_restart = 1'b1;
      end
      TRACK: begin
        if (sample_en) begin
          if (seg_in == r_cand) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == LP_STABLE) w_state_nxt = DECODE;
          end else begin
            w_restart = 1'b1;
          end
        end
      end
      DECODE: begin
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (sample_en && (seg_in != r_cand)) w_restart = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // A new pattern always opens a fresh run of length one.
    if (w_restart) begin
      w_cand_nxt  = seg_in;
      w_cnt_nxt   = 4'd1;
      w_state_nxt = LP_ONE ? DECODE : TRACK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cand  <= 7'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_heroe <= 3'd0;
      r_mov   <= 2'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == DECODE) begin
        if (w_legal) begin
          r_valid <= 1'b1;
          r_mov   <= w_dec_mov;
          if (!w_is_mov) r_heroe <= w_dec_heroe;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

`ifdef SEGDEC_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if ((r_state == DECODE) && !w_legal && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

  assign heroe_out = r_heroe;
  assign mov_out   = r_mov;
  assign valid     = r_valid;
  assign err       = r_err;

  a_pulse_excl: assert property (@(posedge clk) !(r_valid && r_err));

endmodule
